// File: rtl/sprite_pixel_fetch.sv
`timescale 1ns/1ps
// Sprite pixel fetch: picks one object per pixel by priority, reads the sprite-sheet ROM and
// composites the colour-keyed texel over the background, with sync delayed to stay aligned.
module sprite_pixel_fetch #(
   parameter int             N_OBJ     = 4,
   parameter int             AW        = 17,
   parameter int             CW        = 12,
   parameter int             ROM_LAT   = 1,
   parameter logic [CW-1:0]  KEY       = 12'h0F0,
   parameter logic           SYNC_IDLE = 1'b1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  valid,
   input  logic                  hsync_in,
   input  logic                  vsync_in,
   input  logic [CW-1:0]         bg_rgb,
   input  logic [N_OBJ-1:0]      obj_en,
   input  logic [N_OBJ*AW-1:0]   obj_addr,
   output logic [AW-1:0]         rom_addr,
   input  logic [CW-1:0]         rom_data,
   output logic [CW-1:0]         rgb_out,
   output logic                  hsync_out,
   output logic                  vsync_out,
   output logic [AW-1:0]         opaque_cnt
);

   localparam int L = ROM_LAT + 2;

   logic                w_hit;
   logic [AW-1:0]       w_addr;
   logic                w_opaque;
   logic                w_vsFall;

   logic [ROM_LAT:0]    r_validP;
   logic [ROM_LAT:0]    r_hitP;
   logic [CW-1:0]       r_bgP [0:ROM_LAT];
   logic [L-1:0]        r_hsDly;
   logic [L-1:0]        r_vsDly;
   logic [AW-1:0]       r_frameCnt;

   // Scan from the top so the lowest set index is the last one written and wins.
   always_comb begin
      w_hit  = 1'b0;
      w_addr = '0;
      for (int i = N_OBJ - 1; i >= 0; i--) begin
         if (obj_en[i]) begin
            w_hit  = 1'b1;
            w_addr = obj_addr[i*AW +: AW];
         end
      end
   end

   // Index 0 is the address stage; index ROM_LAT lines up with the returning rom_data.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rom_addr <= '0;
         r_validP <= '0;
         r_hitP   <= '0;
         for (int i = 0; i <= ROM_LAT; i++) begin
            r_bgP[i] <= '0;
         end
      end else begin
         rom_addr <= (valid && w_hit) ? w_addr : '0;
         r_validP <= {r_validP[ROM_LAT-1:0], valid};
         r_hitP   <= {r_hitP[ROM_LAT-1:0], w_hit};
         r_bgP[0] <= bg_rgb;
         for (int i = 1; i <= ROM_LAT; i++) begin
            r_bgP[i] <= r_bgP[i-1];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_hsDly <= {L{SYNC_IDLE}};
         r_vsDly <= {L{SYNC_IDLE}};
      end else begin
         r_hsDly <= {r_hsDly[L-2:0], hsync_in};
         r_vsDly <= {r_vsDly[L-2:0], vsync_in};
      end
   end

   assign hsync_out = r_hsDly[L-1];
   assign vsync_out = r_vsDly[L-1];

   // The vsync edge is judged on the value about to reach the pin, in step with rgb_out.
   assign w_vsFall = (r_vsDly[L-1] == SYNC_IDLE) && (r_vsDly[L-2] != SYNC_IDLE);
   assign w_opaque = r_validP[ROM_LAT] && r_hitP[ROM_LAT] && (rom_data != KEY);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rgb_out    <= '0;
         opaque_cnt <= '0;
         r_frameCnt <= '0;
      end else begin
         if (!r_validP[ROM_LAT]) begin
            rgb_out <= '0;
         end else if (w_opaque) begin
            rgb_out <= rom_data;
         end else begin
            rgb_out <= r_bgP[ROM_LAT];
         end
         if (w_vsFall) begin
            opaque_cnt <= r_frameCnt;
            r_frameCnt <= w_opaque ? AW'(1) : '0;
         end else if (w_opaque && (r_frameCnt != '1)) begin
            r_frameCnt <= r_frameCnt + AW'(1);
         end
      end
   end

endmodule

// File: tb/tb_sprite_pixel_fetch.sv
`timescale 1ns/1ps
// Bench for sprite_pixel_fetch: ROM_LAT=1 and ROM_LAT=3 instances share one stimulus stream and
// are compared every cycle against a pixel-history reference model.
module tb_sprite_pixel_fetch;
   localparam int            N_OBJ = 4;
   localparam int            AW    = 17;
   localparam int            CW    = 12;
   localparam logic [CW-1:0] KEY   = 12'h0F0;
   localparam int            HIST  = 8192;

   typedef struct {
      logic          valid;
      logic          hit;
      logic [AW-1:0] addr;
      logic [CW-1:0] bg;
      logic          hs;
      logic          vs;
   } pixel_t;

   logic                clk = 1'b0;
   logic                rstN;
   logic                valid;
   logic                hsyncIn;
   logic                vsyncIn;
   logic [CW-1:0]       bgRgb;
   logic [N_OBJ-1:0]    objEn;
   logic [N_OBJ*AW-1:0] objAddr;

   logic [AW-1:0] romAddr1, romAddr3, opaqueCnt1, opaqueCnt3;
   logic [CW-1:0] romData1, romData3, rgbOut1, rgbOut3;
   logic          hsyncOut1, hsyncOut3, vsyncOut1, vsyncOut3;

   logic [CW-1:0] romPipe1;
   logic [CW-1:0] romPipe3 [0:2];

   pixel_t        hist [HIST];
   pixel_t        resetPix;
   int            edgeN;
   int            testsRun = 0;
   int            testsFailed = 0;
   string         phase;
   int            lat [2] = '{3, 5};
   logic [AW-1:0] mCnt [2];
   logic [AW-1:0] mLatched [2];
   logic          mPrevVs [2];
   logic          rHs, rVs;
   logic [AW-1:0] ra [4];

   always #5 clk = ~clk;

   sprite_pixel_fetch #(.ROM_LAT(1)) dut1 (
      .clk(clk), .rst_n(rstN), .valid(valid), .hsync_in(hsyncIn), .vsync_in(vsyncIn),
      .bg_rgb(bgRgb), .obj_en(objEn), .obj_addr(objAddr), .rom_addr(romAddr1),
      .rom_data(romData1), .rgb_out(rgbOut1), .hsync_out(hsyncOut1), .vsync_out(vsyncOut1),
      .opaque_cnt(opaqueCnt1)
   );

   sprite_pixel_fetch #(.ROM_LAT(3)) dut3 (
      .clk(clk), .rst_n(rstN), .valid(valid), .hsync_in(hsyncIn), .vsync_in(vsyncIn),
      .bg_rgb(bgRgb), .obj_en(objEn), .obj_addr(objAddr), .rom_addr(romAddr3),
      .rom_data(romData3), .rgb_out(rgbOut3), .hsync_out(hsyncOut3), .vsync_out(vsyncOut3),
      .opaque_cnt(opaqueCnt3)
   );

   // Sheet contents: a few fixed texels for the directed cases, keyed holes, hashed elsewhere.
   function automatic logic [CW-1:0] romFn(input logic [AW-1:0] a);
      logic [AW-1:0] h;
      if (a == 17'd641) return 12'hABC;
      if (a == 17'd5) return KEY;
      if (a == 17'd9) return 12'h9F9;
      if (a[2:0] == 3'd3) return KEY;
      h = a * 17'd2654 + 17'd1013;
      return h[11:0] ^ {3'b000, h[16:8]};
   endfunction

   // Synchronous ROMs with one and three cycles of read latency.
   always @(posedge clk) begin
      romPipe1    <= romFn(romAddr1);
      romPipe3[0] <= romFn(romAddr3);
      romPipe3[1] <= romPipe3[0];
      romPipe3[2] <= romPipe3[1];
   end

   assign romData1 = romPipe1;
   assign romData3 = romPipe3[2];

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      testsRun++;
      assert (obs === expv) else begin
         testsFailed++;
         $error("[TB] FAIL %s: observed %0h, expected %0h", tag, obs, expv);
      end
   endtask

   task automatic resetModel();
      edgeN = 0;
      for (int d = 0; d < 2; d++) begin
         mCnt[d]     = '0;
         mLatched[d] = '0;
         mPrevVs[d]  = 1'b1;
      end
   endtask

   // Each pixel captured at edge e must leave the outputs after edge e+L-1.
   task automatic checkAll();
      pixel_t        p;
      int            idx;
      logic [CW-1:0] tex;
      logic [CW-1:0] expRgb;
      logic          opq;
      for (int d = 0; d < 2; d++) begin
         idx = edgeN - lat[d] + 1;
         p   = (idx >= 1) ? hist[idx] : resetPix;
         tex = romFn(p.addr);
         opq = p.valid && p.hit && (tex != KEY);
         expRgb = !p.valid ? '0 : (opq ? tex : p.bg);
         if (mPrevVs[d] && !p.vs) begin
            mLatched[d] = mCnt[d];
            mCnt[d]     = {{(AW-1){1'b0}}, opq};
         end else if (opq && (mCnt[d] != '1)) begin
            mCnt[d] = mCnt[d] + 1'b1;
         end
         mPrevVs[d] = p.vs;
         checkOutput($sformatf("%s rgb L%0d e%0d", phase, lat[d], edgeN),
                     32'(d == 0 ? rgbOut1 : rgbOut3), 32'(expRgb));
         checkOutput($sformatf("%s hsync L%0d e%0d", phase, lat[d], edgeN),
                     32'(d == 0 ? hsyncOut1 : hsyncOut3), 32'(p.hs));
         checkOutput($sformatf("%s vsync L%0d e%0d", phase, lat[d], edgeN),
                     32'(d == 0 ? vsyncOut1 : vsyncOut3), 32'(p.vs));
         checkOutput($sformatf("%s opaqueCnt L%0d e%0d", phase, lat[d], edgeN),
                     32'(d == 0 ? opaqueCnt1 : opaqueCnt3), 32'(mLatched[d]));
         checkOutput($sformatf("%s romAddr L%0d e%0d", phase, lat[d], edgeN),
                     32'(d == 0 ? romAddr1 : romAddr3),
                     32'((hist[edgeN].valid && hist[edgeN].hit) ? hist[edgeN].addr : '0));
      end
   endtask

   task automatic applyStimulus(input logic v, input logic hs, input logic vs,
                                input logic [CW-1:0] bg, input logic [N_OBJ-1:0] en,
                                input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                                input logic [AW-1:0] a2, input logic [AW-1:0] a3);
      pixel_t        p;
      logic [AW-1:0] addrs [N_OBJ];
      if (edgeN + 1 >= HIST) begin
         $display("[TB] FAIL history: observed edge %0d, required below %0d", edgeN + 1, HIST);
         $fatal(1, "[TB] history exhausted");
      end
      addrs  = '{a0, a1, a2, a3};
      p.valid = v;
      p.hit   = (en != '0);
      p.addr  = '0;
      for (int i = 0; i < N_OBJ; i++) begin
         if (en[i]) begin
            p.addr = addrs[i];
            break;
         end
      end
      p.bg = bg;
      p.hs = hs;
      p.vs = vs;
      valid   = v;
      hsyncIn = hs;
      vsyncIn = vs;
      bgRgb   = bg;
      objEn   = en;
      objAddr = {a3, a2, a1, a0};
      hist[edgeN + 1] = p;
      @(posedge clk);
      edgeN++;
      #1;
      checkAll();
   endtask

   task automatic idleCycles(input int n, input logic hs, input logic vs);
      repeat (n) applyStimulus(1'b1, hs, vs, 12'h000, 4'b0000, '0, '0, '0, '0);
   endtask

   task automatic checkReset(input string tag);
      checkOutput({tag, " rgb L3"}, 32'(rgbOut1), 32'd0);
      checkOutput({tag, " rgb L5"}, 32'(rgbOut3), 32'd0);
      checkOutput({tag, " hsync L3"}, 32'(hsyncOut1), 32'd1);
      checkOutput({tag, " hsync L5"}, 32'(hsyncOut3), 32'd1);
      checkOutput({tag, " vsync L3"}, 32'(vsyncOut1), 32'd1);
      checkOutput({tag, " vsync L5"}, 32'(vsyncOut3), 32'd1);
      checkOutput({tag, " romAddr L3"}, 32'(romAddr1), 32'd0);
      checkOutput({tag, " romAddr L5"}, 32'(romAddr3), 32'd0);
      checkOutput({tag, " opaqueCnt L3"}, 32'(opaqueCnt1), 32'd0);
      checkOutput({tag, " opaqueCnt L5"}, 32'(opaqueCnt3), 32'd0);
   endtask

   initial begin
      resetPix = '{valid: 1'b0, hit: 1'b0, addr: '0, bg: '0, hs: 1'b1, vs: 1'b1};
      rstN    = 1'b1;
      valid   = 1'b0;
      hsyncIn = 1'b1;
      vsyncIn = 1'b1;
      bgRgb   = '0;
      objEn   = '0;
      objAddr = '0;
      phase   = "por";
      resetModel();
      #1 rstN = 1'b0;
      #2 checkReset("por");
      repeat (2) @(posedge clk);
      #3 rstN = 1'b1;

      phase = "t1";
      applyStimulus(1'b1, 1'b1, 1'b1, 12'h555, 4'b0001, 17'd641, '0, '0, '0);
      checkOutput("t1 romAddr L3", 32'(romAddr1), 32'd641);
      checkOutput("t1 romAddr L5", 32'(romAddr3), 32'd641);
      idleCycles(2, 1'b1, 1'b1);
      checkOutput("t1 rgb L3", 32'(rgbOut1), 32'hABC);
      idleCycles(2, 1'b1, 1'b1);
      checkOutput("t1 rgb L5", 32'(rgbOut3), 32'hABC);

      phase = "t2";
      applyStimulus(1'b1, 1'b1, 1'b1, 12'h123, 4'b0110, 17'd641, 17'd5, 17'd9, '0);
      checkOutput("t2 romAddr L3", 32'(romAddr1), 32'd5);
      checkOutput("t2 romAddr L5", 32'(romAddr3), 32'd5);
      idleCycles(2, 1'b1, 1'b1);
      checkOutput("t2 rgb L3", 32'(rgbOut1), 32'h123);
      idleCycles(2, 1'b1, 1'b1);
      checkOutput("t2 rgb L5", 32'(rgbOut3), 32'h123);

      phase = "t3";
      applyStimulus(1'b0, 1'b1, 1'b1, 12'h456, 4'b1111, 17'd641, 17'd5, 17'd9, 17'd7);
      checkOutput("t3 romAddr L3", 32'(romAddr1), 32'd0);
      checkOutput("t3 romAddr L5", 32'(romAddr3), 32'd0);
      idleCycles(2, 1'b1, 1'b1);
      checkOutput("t3 rgb L3", 32'(rgbOut1), 32'd0);
      idleCycles(2, 1'b1, 1'b1);
      checkOutput("t3 rgb L5", 32'(rgbOut3), 32'd0);
      for (int n = 0; n < 96; n++) begin
         applyStimulus(1'b1, 1'b0, 1'b1, CW'($urandom), 4'b0001, 17'd641, '0, '0, '0);
      end
      idleCycles(8, 1'b1, 1'b1);

      phase = "rand";
      rHs = 1'b1;
      rVs = 1'b1;
      for (int n = 0; n < 1500; n++) begin
         if ($urandom_range(0, 29) == 0) rHs = ~rHs;
         if ($urandom_range(0, 59) == 0) rVs = ~rVs;
         for (int i = 0; i < 4; i++) begin
            ra[i] = ($urandom_range(0, 2) == 0) ? AW'(8 * $urandom_range(0, 500) + 3) : AW'($urandom);
         end
         applyStimulus($urandom_range(0, 9) != 0, rHs, rVs, CW'($urandom),
                       N_OBJ'($urandom_range(0, 15)), ra[0], ra[1], ra[2], ra[3]);
      end

      phase = "t5";
      repeat (6) applyStimulus(1'b1, 1'b0, 1'b0, 12'h321, 4'b0001, 17'd641, '0, '0, '0);
      #2 rstN = 1'b0;
      #1 checkReset("t5 async");
      repeat (2) @(posedge clk);
      #3 rstN = 1'b1;
      resetModel();
      repeat (8) applyStimulus(1'b1, 1'b1, 1'b1, 12'h777, 4'b0010, '0, 17'd641, '0, '0);

      phase = "t4";
      idleCycles(8, 1'b1, 1'b1);
      idleCycles(3, 1'b1, 1'b0);
      repeat (200) applyStimulus(1'b1, 1'b1, 1'b1, 12'h111, 4'b0001, 17'd641, '0, '0, '0);
      idleCycles(10, 1'b1, 1'b1);
      idleCycles(8, 1'b1, 1'b0);
      checkOutput("t4 frame200 L3", 32'(opaqueCnt1), 32'd200);
      checkOutput("t4 frame200 L5", 32'(opaqueCnt3), 32'd200);
      idleCycles(50, 1'b1, 1'b1);
      idleCycles(8, 1'b1, 1'b0);
      checkOutput("t4 frame0 L3", 32'(opaqueCnt1), 32'd0);
      checkOutput("t4 frame0 L5", 32'(opaqueCnt3), 32'd0);

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
